// File: rtl/layer_config_sequencer_if.sv
// Parameter stream and shared layer configuration bus of the weight/bias sequencer.
// The slave side is the sequencer; the master side feeds words and watches the strobes.
interface layer_config_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [31:0]           config_layer_num;
    logic [31:0]           config_neuron_num;
    logic [DATA_WIDTH-1:0] weight_value;
    logic                  weight_valid;
    logic [DATA_WIDTH-1:0] bias_value;
    logic                  bias_valid;

    modport slave (
        input  s_data, s_valid,
        output s_ready, config_layer_num, config_neuron_num,
               weight_value, weight_valid, bias_value, bias_valid
    );

    modport master (
        output s_data, s_valid,
        input  s_ready, config_layer_num, config_neuron_num,
               weight_value, weight_valid, bias_value, bias_valid
    );
endinterface

// File: rtl/layer_config_sequencer.sv
// Streams weight and bias words into the 4-layer network in layer/neuron/weight order.
// Optional running checksum of accepted words: define CFG_CHECKSUM_EN.
module layer_config_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int L1_NEURONS = 30,
    parameter int L1_WEIGHTS = 784,
    parameter int L2_NEURONS = 30,
    parameter int L2_WEIGHTS = 30,
    parameter int L3_NEURONS = 10,
    parameter int L3_WEIGHTS = 30,
    parameter int L4_NEURONS = 10,
    parameter int L4_WEIGHTS = 10
) (
    input  logic                          s_axi_aclk,
    input  logic                          reset,
    input  logic                          start,
    layer_config_sequencer_if.slave       bus,
    output logic                          busy,
    output logic                          done,
    output logic [31:0]                   words_loaded
`ifdef CFG_CHECKSUM_EN
    ,
    input  logic [31:0]                   expected_checksum,
    output logic [31:0]                   checksum,
    output logic                          checksum_match
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WEIGHT,
        BIAS,
        FINISH,
        DONE
    } state_t;

    state_t                r_state;
    logic [2:0]            r_layer;
    logic [31:0]           r_neuron;
    logic [31:0]           r_weight;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic [31:0]           r_words;
    logic [31:0]           r_cfgLayer;
    logic [31:0]           r_cfgNeuron;
    logic [DATA_WIDTH-1:0] r_weightValue;
    logic                  r_weightValid;
    logic [DATA_WIDTH-1:0] r_biasValue;
    logic                  r_biasValid;

    logic w_accept;
    logic w_startAccept;

    assign w_accept      = bus.s_valid && r_ready;
    assign w_startAccept = start && (r_state == IDLE);

    function automatic logic [31:0] weightsOf(input logic [2:0] layer);
        case (layer)
            3'd1:    weightsOf = 32'(L1_WEIGHTS);
            3'd2:    weightsOf = 32'(L2_WEIGHTS);
            3'd3:    weightsOf = 32'(L3_WEIGHTS);
            default: weightsOf = 32'(L4_WEIGHTS);
        endcase
    endfunction

    function automatic logic [31:0] neuronsOf(input logic [2:0] layer);
        case (layer)
            3'd1:    neuronsOf = 32'(L1_NEURONS);
            3'd2:    neuronsOf = 32'(L2_NEURONS);
            3'd3:    neuronsOf = 32'(L3_NEURONS);
            default: neuronsOf = 32'(L4_NEURONS);
        endcase
    endfunction

    // FINISH is the cycle carrying the last bias strobe; DONE is the done-pulse cycle, still busy.
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_layer       <= 3'd0;
            r_neuron      <= 32'd0;
            r_weight      <= 32'd0;
            r_ready       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_words       <= 32'd0;
            r_cfgLayer    <= 32'd0;
            r_cfgNeuron   <= 32'd0;
            r_weightValue <= '0;
            r_weightValid <= 1'b0;
            r_biasValue   <= '0;
            r_biasValid   <= 1'b0;
        end else begin
            r_weightValid <= 1'b0;
            r_biasValid   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= WEIGHT;
                        r_layer  <= 3'd1;
                        r_neuron <= 32'd0;
                        r_weight <= 32'd0;
                        r_words  <= 32'd0;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                WEIGHT: begin
                    if (w_accept) begin
                        r_weightValid <= 1'b1;
                        r_weightValue <= bus.s_data;
                        r_cfgLayer    <= {29'd0, r_layer};
                        r_cfgNeuron   <= r_neuron;
                        r_words       <= r_words + 32'd1;
                        r_weight      <= r_weight + 32'd1;
                        if (r_weight == weightsOf(r_layer) - 32'd1) begin
                            r_state <= BIAS;
                        end
                    end
                end
                BIAS: begin
                    if (w_accept) begin
                        r_biasValid <= 1'b1;
                        r_biasValue <= bus.s_data;
                        r_cfgLayer  <= {29'd0, r_layer};
                        r_cfgNeuron <= r_neuron;
                        r_words     <= r_words + 32'd1;
                        r_weight    <= 32'd0;
                        r_state     <= WEIGHT;
                        if (r_neuron == neuronsOf(r_layer) - 32'd1) begin
                            r_neuron <= 32'd0;
                            if (r_layer == 3'd4) begin
                                r_state <= FINISH;
                                r_ready <= 1'b0;
                            end else begin
                                r_layer <= r_layer + 3'd1;
                            end
                        end else begin
                            r_neuron <= r_neuron + 32'd1;
                        end
                    end
                end
                FINISH: begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready           = r_ready;
    assign bus.config_layer_num  = r_cfgLayer;
    assign bus.config_neuron_num = r_cfgNeuron;
    assign bus.weight_value      = r_weightValue;
    assign bus.weight_valid      = r_weightValid;
    assign bus.bias_value        = r_biasValue;
    assign bus.bias_valid        = r_biasValid;
    assign busy                  = r_busy;
    assign done                  = r_done;
    assign words_loaded          = r_words;

`ifdef CFG_CHECKSUM_EN
    logic [31:0] r_checksum;
    logic        r_match;
    logic [31:0] w_beat32;

    if (DATA_WIDTH >= 32) begin : g_trunc
        assign w_beat32 = bus.s_data[31:0];
    end else begin : g_extend
        assign w_beat32 = {{(32 - DATA_WIDTH){1'b0}}, bus.s_data};
    end

    // The sum is final once the last bias is taken, so the match is latched as done rises.
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            r_checksum <= 32'd0;
            r_match    <= 1'b0;
        end else if (w_startAccept) begin
            r_checksum <= 32'd0;
            r_match    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_checksum <= r_checksum + w_beat32;
            end
            if (r_state == FINISH) begin
                r_match <= (r_checksum == expected_checksum);
            end
        end
    end

    assign checksum       = r_checksum;
    assign checksum_match = r_match;
`endif

endmodule

// File: tb/tb_layer_config_sequencer.sv
// Self-checking bench for layer_config_sequencer with small layer sizes (2/3, 2/2, 1/2, 1/1).
// A word-level model derived from the stream order is compared against the DUT every cycle.
module tb_layer_config_sequencer;

    localparam int DW    = 32;
    localparam int N1 = 2, W1 = 3, N2 = 2, W2 = 2, N3 = 1, W3 = 2, N4 = 1, W4 = 1;
    localparam int TOTAL = N1 * (W1 + 1) + N2 * (W2 + 1) + N3 * (W3 + 1) + N4 * (W4 + 1);

    logic        clock;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] wordsLoaded;
`ifdef CFG_CHECKSUM_EN
    logic [31:0] expectedChecksum;
    logic [31:0] checksum;
    logic        checksumMatch;
`endif

    layer_config_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    layer_config_sequencer #(
        .DATA_WIDTH(DW),
        .L1_NEURONS(N1), .L1_WEIGHTS(W1),
        .L2_NEURONS(N2), .L2_WEIGHTS(W2),
        .L3_NEURONS(N3), .L3_WEIGHTS(W3),
        .L4_NEURONS(N4), .L4_WEIGHTS(W4)
    ) dut (
        .s_axi_aclk        (clock),
        .reset             (reset),
        .start             (start),
        .bus               (bus.slave),
        .busy              (busy),
        .done              (done),
        .words_loaded      (wordsLoaded)
`ifdef CFG_CHECKSUM_EN
        ,
        .expected_checksum (expectedChecksum),
        .checksum          (checksum),
        .checksum_match    (checksumMatch)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit isBias;
        int layer;
        int neuron;
    } planItem_t;

    typedef struct {
        bit          isBias;
        int          layer;
        int          neuron;
        logic [31:0] value;
        int          cyc;
    } obsItem_t;

    planItem_t plan[$];
    obsItem_t  obs[$];
    int        doneSeen  = 0;
    int        doneCycle = 0;
    int        cyc       = 0;
    bit        checkEnable = 0;

    // Model state: what the outputs must be in the current cycle
    bit          mBusy = 0;
    int          mCount = 0;
    int          mCountdown = 0;
    bit          eReady = 0, eWV = 0, eBV = 0, eDone = 0;
    logic [31:0] eLayer = 0, eNeuron = 0, eWVal = 0, eBVal = 0, eWords = 0, eSum = 0;
    bit          eMatch = 0;

    function automatic int neuronsOf(input int l);
        return (l == 1) ? N1 : (l == 2) ? N2 : (l == 3) ? N3 : N4;
    endfunction

    function automatic int weightsOf(input int l);
        return (l == 1) ? W1 : (l == 2) ? W2 : (l == 3) ? W3 : W4;
    endfunction

    task automatic buildPlan();
        planItem_t p;
        plan.delete();
        for (int l = 1; l <= 4; l++) begin
            for (int n = 0; n < neuronsOf(l); n++) begin
                for (int w = 0; w < weightsOf(l); w++) begin
                    p.isBias = 0; p.layer = l; p.neuron = n;
                    plan.push_back(p);
                end
                p.isBias = 1; p.layer = l; p.neuron = n;
                plan.push_back(p);
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Model advances on every rising edge from the bench-driven inputs only.
    always @(posedge clock) begin : model
        bit        acc;
        bit        prevDone;
        bit        startAcc;
        planItem_t item;
        cyc++;
        if (reset) begin
            mBusy = 0; mCount = 0; mCountdown = 0;
            eReady = 0; eWV = 0; eBV = 0; eDone = 0;
            eLayer = 0; eNeuron = 0; eWVal = 0; eBVal = 0; eWords = 0; eSum = 0; eMatch = 0;
        end else begin
            acc      = bus.s_valid && eReady;
            prevDone = eDone;
            startAcc = start && !mBusy;
            eWV = 0; eBV = 0; eDone = 0;
            if (acc) begin
                item    = plan[mCount];
                eLayer  = item.layer;
                eNeuron = item.neuron;
                if (item.isBias) begin eBV = 1; eBVal = bus.s_data; end
                else             begin eWV = 1; eWVal = bus.s_data; end
                eWords = eWords + 1;
                eSum   = eSum + bus.s_data;
                mCount++;
                if (mCount == TOTAL) mCountdown = 1;
            end else if (mCountdown != 0) begin
                mCountdown--;
                if (mCountdown == 0) begin
                    eDone = 1;
`ifdef CFG_CHECKSUM_EN
                    eMatch = (eSum == expectedChecksum);
`endif
                end
            end
            if (prevDone) mBusy = 0;
            if (startAcc) begin
                mBusy = 1; mCount = 0; mCountdown = 0;
                eWords = 0; eSum = 0; eMatch = 0;
            end
            eReady = mBusy && (mCount < TOTAL);
        end
    end

    // Compare process: every output against the model, and record strobes for literal checks.
    always @(negedge clock) begin
        obsItem_t o;
        if (checkEnable) begin
            checkOutput("s_ready", 32'(bus.s_ready), 32'(eReady));
            checkOutput("weight_valid", 32'(bus.weight_valid), 32'(eWV));
            checkOutput("bias_valid", 32'(bus.bias_valid), 32'(eBV));
            checkOutput("config_layer_num", bus.config_layer_num, eLayer);
            checkOutput("config_neuron_num", bus.config_neuron_num, eNeuron);
            checkOutput("weight_value", bus.weight_value, eWVal);
            checkOutput("bias_value", bus.bias_value, eBVal);
            checkOutput("busy", 32'(busy), 32'(mBusy));
            checkOutput("done", 32'(done), 32'(eDone));
            checkOutput("words_loaded", wordsLoaded, eWords);
`ifdef CFG_CHECKSUM_EN
            checkOutput("checksum", checksum, eSum);
            checkOutput("checksum_match", 32'(checksumMatch), 32'(eMatch));
`endif
            if (bus.weight_valid || bus.bias_valid) begin
                o.isBias = bus.bias_valid;
                o.layer  = int'(bus.config_layer_num);
                o.neuron = int'(bus.config_neuron_num);
                o.value  = bus.bias_valid ? bus.bias_value : bus.weight_value;
                o.cyc    = cyc;
                obs.push_back(o);
            end
            if (done) begin
                doneSeen++;
                doneCycle = cyc;
            end
        end
    end

    task automatic pulseStart();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic applyStimulus(input int nWords, input int gap, input int restartAt);
        for (int i = 0; i < nWords; i++) begin
            int tries;
            @(negedge clock);
            start       = (i == restartAt);
            bus.s_valid = 1'b1;
            bus.s_data  = 32'(i + 1);
            tries = 0;
            while (!bus.s_ready && tries < 100) begin
                @(negedge clock);
                start = 1'b0;
                tries++;
            end
            if (tries >= 100) begin
                checks++; errors++;
                $display("[TB] FAIL stream_timeout actual=no_ready required=ready word=%0d", i + 1);
                bus.s_valid = 1'b0;
                start = 1'b0;
                return;
            end
            if (gap != 0) begin
                @(negedge clock);
                start       = 1'b0;
                bus.s_valid = 1'b0;
            end
        end
        @(negedge clock);
        start       = 1'b0;
        bus.s_valid = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (n >= 60) begin
            checks++; errors++;
            $display("[TB] FAIL done_timeout actual=0 required=1");
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic checkStrobe(input string name, input int idx, input bit isBias,
                               input int layer, input int neuron, input int value);
        if (idx >= obs.size()) begin
            checks++; errors++;
            $display("[TB] FAIL %s actual=missing required=strobe_%0d", name, idx);
        end else begin
            checkOutput({name, "_kind"}, 32'(obs[idx].isBias), 32'(isBias));
            checkOutput({name, "_layer"}, 32'(obs[idx].layer), 32'(layer));
            checkOutput({name, "_neuron"}, 32'(obs[idx].neuron), 32'(neuron));
            checkOutput({name, "_value"}, obs[idx].value, 32'(value));
        end
    endtask

    task automatic checkSequence(input string name, input int spacing);
        bit ok = 1;
        checkOutput({name, "_strobes"}, 32'(obs.size()), 32'd19);
        checkOutput({name, "_dones"}, 32'(doneSeen), 32'd1);
        checkStrobe({name, "_first"}, 0, 0, 1, 0, 1);
        checkStrobe({name, "_bias4"}, 3, 1, 1, 0, 4);
        checkStrobe({name, "_last"}, 18, 1, 4, 0, 19);
        for (int i = 1; i < obs.size(); i++) begin
            if (obs[i].cyc - obs[i-1].cyc != spacing) ok = 0;
        end
        checkOutput({name, "_spacing"}, 32'(ok), 32'd1);
        if (obs.size() > 0) begin
            checkOutput({name, "_done_timing"}, 32'(doneCycle), 32'(obs[obs.size()-1].cyc + 1));
        end
        checkOutput({name, "_words"}, wordsLoaded, 32'd19);
    endtask

    task automatic clearObs();
        obs.delete();
        doneSeen = 0;
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
`ifdef CFG_CHECKSUM_EN
        expectedChecksum = 32'd190;
`endif
        buildPlan();
        checkOutput("plan_length", 32'(plan.size()), 32'd19);
        @(negedge clock);
        checkEnable = 1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_ready", 32'(bus.s_ready), 32'd0);
        checkOutput("reset_words", wordsLoaded, 32'd0);
        checkOutput("reset_layer", bus.config_layer_num, 32'd0);

        $display("[TB] back-to-back load");
        clearObs();
        pulseStart();
        applyStimulus(19, 0, -1);
        waitDone();
        checkSequence("b2b", 1);
`ifdef CFG_CHECKSUM_EN
        checkOutput("b2b_checksum", checksum, 32'd190);
        checkOutput("b2b_match", 32'(checksumMatch), 32'd1);
        expectedChecksum = 32'd191;
`endif

        $display("[TB] gapped load");
        clearObs();
        pulseStart();
        applyStimulus(19, 1, -1);
        waitDone();
        checkSequence("gap", 2);
`ifdef CFG_CHECKSUM_EN
        checkOutput("gap_checksum", checksum, 32'd190);
        checkOutput("gap_match", 32'(checksumMatch), 32'd0);
`endif

        $display("[TB] reset mid-sequence");
        pulseStart();
        applyStimulus(7, 0, -1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midreset_ready", 32'(bus.s_ready), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_words", wordsLoaded, 32'd0);
        checkOutput("midreset_layer", bus.config_layer_num, 32'd0);
        checkOutput("midreset_weight", bus.weight_value, 32'd0);
        clearObs();
        pulseStart();
        applyStimulus(19, 0, -1);
        waitDone();
        checkSequence("reload", 1);

        $display("[TB] start while busy");
        clearObs();
        pulseStart();
        applyStimulus(19, 0, 4);
        waitDone();
        checkSequence("restart", 1);

        $display("[TB] beats in idle");
        clearObs();
        @(negedge clock);
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hAA;
        repeat (5) @(negedge clock);
        bus.s_valid = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("idle_strobes", 32'(obs.size()), 32'd0);
        checkOutput("idle_words", wordsLoaded, 32'd19);

        checkEnable = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
